branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 85 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counters with a target per entry.
// Lookup is purely combinational; resolved branches from execute train the table on clk.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_pc,
    output logic        f_taken,
    output logic [31:0] f_next_pc,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_taken,
    input  logic [31:0] u_target,
    input  logic        u_pred_taken,
    output logic        u_mispredict,
    output logic [15:0] mispredict_cnt
);
    localparam int DEPTH = 2 ** IDX_BITS;
    localparam int TAG_W = 32 - IDX_BITS - 2;

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [1:0]        ctr_q    [DEPTH];
    logic [31:0]       target_q [DEPTH];

    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [TAG_W-1:0]    u_tag;
    logic                f_hit;
    logic                u_hit;

    // Instruction-aligned PCs: the low two bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[1:0], u_pc[1:0]};

    assign f_idx = f_pc[IDX_BITS+1:2];
    assign f_tag = f_pc[31:IDX_BITS+2];
    assign u_idx = u_pc[IDX_BITS+1:2];
    assign u_tag = u_pc[31:IDX_BITS+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign f_taken      = f_hit & ctr_q[f_idx][1];
    assign f_next_pc    = f_taken ? target_q[f_idx] : f_pc + 32'd4;
    assign u_mispredict = u_valid & (u_taken ^ u_pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= 32'd0;
            end
        end else if (u_valid) begin
            if (u_hit) begin
                if (u_taken) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                    end
                    target_q[u_idx] <= u_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                end
            end else if (u_taken) begin
                // Not-taken misses are never allocated, so only taken branches evict.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                ctr_q[u_idx]    <= 2'b10;
                target_q[u_idx] <= u_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= 16'd0;
        end else if (u_mispredict && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end
endmodule
